// File: rtl/row_hamming_enc.sv
// Two-stage elastic encoder: binary row address -> Gray code -> Hamming(12,8)
// codeword laid out for the emulator's row-address decoder, with optional single-bit flip.
module row_hamming_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_addr,
  input  logic        err_en,
  input  logic [3:0]  err_pos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_code,
  output logic [15:0] word_cnt
);

  logic        r_s1_valid;
  logic [7:0]  r_s1_gray;
  logic [11:0] r_s1_flip;
  logic        r_s2_valid;
  logic [11:0] r_s2_code;
  logic [15:0] r_word_cnt;

  logic        w_s1_load;
  logic        w_s2_load;
  logic        w_out_hs;
  logic        w_in_ready;
  logic [7:0]  w_gray;
  logic [11:0] w_flip;

  function automatic logic [11:0] hamming_encode(input logic [7:0] g);
    logic [11:0] c;
    c      = 12'h000;
    c[2]   = g[0];
    c[4]   = g[1];
    c[5]   = g[2];
    c[11]  = g[3];
    c[8]   = g[4];
    c[9]   = g[5];
    c[10]  = g[6];
    c[6]   = g[7];
    c[0]   = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1]   = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3]   = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7]   = c[8] ^ c[9] ^ c[10] ^ c[11];
    return c;
  endfunction

  // Positions 12..15 are not codeword bits, so they yield an all-zero mask.
  function automatic logic [11:0] flip_mask(input logic en, input logic [3:0] pos);
    logic [11:0] m;
    m = 12'h000;
    if (en && (pos < 4'd12)) begin
      m = 12'h001 << pos;
    end else begin
      m = 12'h000;
    end
    return m;
  endfunction

  // Handshake and stage-advance decisions for the elastic pipeline.
  always_comb begin
    w_in_ready = 1'b1;
    w_s1_load  = 1'b0;
    w_s2_load  = 1'b0;
    w_out_hs   = 1'b0;
    w_gray     = 8'h00;
    w_flip     = 12'h000;
    w_in_ready = !r_s1_valid || !r_s2_valid || out_ready;
    w_s1_load  = in_valid && w_in_ready;
    w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
    w_out_hs   = r_s2_valid && out_ready;
    w_gray     = in_addr ^ (in_addr >> 1);
    w_flip     = flip_mask(err_en, err_pos);
  end

  // Pipeline registers and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_gray  <= 8'h00;
      r_s1_flip  <= 12'h000;
      r_s2_valid <= 1'b0;
      r_s2_code  <= 12'h000;
      r_word_cnt <= 16'h0000;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
        r_s1_gray  <= w_gray;
        r_s1_flip  <= w_flip;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= r_s1_valid;
      end

      // The flip is applied after parity so the decoder sees a genuine single-bit error.
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_code  <= hamming_encode(r_s1_gray) ^ r_s1_flip;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s2_valid;
      end

      if (w_out_hs) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end else begin
        r_word_cnt <= r_word_cnt;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_code  = r_s2_code;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_row_hamming_enc.sv
// Self-checking bench for row_hamming_enc: directed vectors, injection, stalls,
// randomized traffic against a queue scoreboard, counter wrap and mid-run reset.
module tb_row_hamming_enc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_addr = 8'h00;
  logic        err_en = 1'b0;
  logic [3:0]  err_pos = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_code;
  logic [15:0] word_cnt;

  row_hamming_enc dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .err_en(err_en), .err_pos(err_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] code;
    logic [7:0]  addr;
    int          acc;
    bit          flipped;
  } item_t;

  item_t       q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          acc_cnt = 0;
  bit          prev_hold = 1'b0;
  logic [11:0] prev_code = 12'h000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Decoder check groups: each parity bit makes the XOR over its group zero.
  localparam logic [11:0] CHK0 = 12'h555;
  localparam logic [11:0] CHK1 = 12'h666;
  localparam logic [11:0] CHK2 = 12'h878;
  localparam logic [11:0] CHK3 = 12'hF80;

  function automatic int data_pos(input int i);
    int p [8] = '{2, 4, 5, 11, 8, 9, 10, 6};
    return p[i];
  endfunction

  function automatic logic [11:0] model_code(input logic [7:0] a, input bit ee, input logic [3:0] ep);
    logic [7:0]  g;
    logic [11:0] c;
    g = a ^ (a >> 1);
    c = 12'h000;
    for (int i = 0; i < 8; i++) c[data_pos(i)] = g[i];
    c[0] = ^(c & CHK0);
    c[1] = ^(c & CHK1);
    c[3] = ^(c & CHK2);
    c[7] = ^(c & CHK3);
    if (ee && (int'(ep) < 12)) c[int'(ep)] = ~c[int'(ep)];
    return c;
  endfunction

  // Returns 9'h100 when any syndrome bit is set.
  function automatic logic [8:0] ref_decode(input logic [11:0] c);
    logic [7:0] g;
    logic [7:0] b;
    if ((^(c & CHK0)) || (^(c & CHK1)) || (^(c & CHK2)) || (^(c & CHK3))) return 9'h100;
    for (int i = 0; i < 8; i++) g[i] = c[data_pos(i)];
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return {1'b0, b};
  endfunction

  task automatic cycle(input bit iv, input logic [7:0] a, input bit ee, input logic [3:0] ep,
                       input bit ordy, input bit use_want, input logic [11:0] want);
    item_t it;
    bit    exp_ov;
    bit    exp_ir;
    @(negedge clk);
    in_valid  = iv;
    in_addr   = a;
    err_en    = ee;
    err_pos   = ep;
    out_ready = ordy;
    #1;
    check_eq("word_cnt", 32'(word_cnt), 32'(hs_cnt & 32'hFFFF));
    exp_ir = (q.size() < 2) || ordy;
    check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    if (prev_hold) check_eq("hold_code", 32'(out_code), 32'(prev_code));
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        check_eq("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        it = q.pop_front();
        check_eq("code", 32'(out_code), 32'(it.code));
        if (!it.flipped) check_eq("decode", 32'(ref_decode(out_code)), 32'(it.addr));
      end
      hs_cnt++;
    end
    if (iv && in_ready) begin
      it.code    = use_want ? want : model_code(a, ee, ep);
      it.addr    = a;
      it.acc     = cyc;
      it.flipped = ee && (int'(ep) < 12);
      q.push_back(it);
      acc_cnt++;
    end
    prev_hold = out_valid && !ordy;
    prev_code = out_code;
    cyc++;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 4'd0, ordy, 1'b0, 12'h000);
  endtask

  initial begin
    logic [7:0]  dir_addr [5] = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h55};
    logic [11:0] dir_code [5] = '{12'h000, 12'h007, 12'h4C8, 12'h04B, 12'hF3C};
    int guard;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_code", 32'(out_code), 32'd0);
    check_eq("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, back-to-back
    for (int i = 0; i < 5; i++) cycle(1'b1, dir_addr[i], 1'b0, 4'd0, 1'b1, 1'b1, dir_code[i]);
    idle(3, 1'b1);
    check_eq("cnt_after_5", 32'(word_cnt), 32'd5);

    // All addresses back-to-back, checked through the reference decoder
    for (int i = 0; i < 256; i++) cycle(1'b1, 8'(i), 1'b0, 4'd0, 1'b1, 1'b0, 12'h000);
    idle(3, 1'b1);

    // Error injection on a single word only
    cycle(1'b1, 8'h01, 1'b1, 4'd5,  1'b1, 1'b1, 12'h027);
    cycle(1'b1, 8'h01, 1'b1, 4'd13, 1'b1, 1'b1, 12'h007);
    cycle(1'b1, 8'h01, 1'b0, 4'd5,  1'b1, 1'b1, 12'h007);
    idle(3, 1'b1);

    // Stall: offer three words with out_ready low
    cycle(1'b1, 8'h10, 1'b0, 4'd0, 1'b0, 1'b0, 12'h000);
    cycle(1'b1, 8'h20, 1'b0, 4'd0, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h30, 1'b0, 4'd0, 1'b0, 1'b0, 12'h000);
    check_eq("stall_accepted", 32'(q.size()), 32'd2);
    cycle(1'b1, 8'h30, 1'b0, 4'd0, 1'b1, 1'b0, 12'h000);
    idle(4, 1'b1);

    // Random traffic with stalls and occasional injection
    guard = 0;
    while ((acc_cnt < 10300) && (guard < 40000)) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b0, 12'h000);
      guard++;
    end
    check_eq("random_budget", 32'(guard < 40000), 32'd1);
    idle(4, 1'b1);

    // Stream until word_cnt wraps past 0xFFFF
    guard = 0;
    while ((hs_cnt < 65540) && (guard < 70000)) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 4'd0, 1'b1, 1'b0, 12'h000);
      guard++;
    end
    idle(4, 1'b1);
    check_eq("wrap_reached", 32'(hs_cnt >= 65536), 32'd1);

    // Reset with both stages full
    cycle(1'b1, 8'h42, 1'b0, 4'd0, 1'b0, 1'b0, 12'h000);
    cycle(1'b1, 8'h43, 1'b0, 4'd0, 1'b0, 1'b0, 12'h000);
    cycle(1'b1, 8'h44, 1'b0, 4'd0, 1'b0, 1'b0, 12'h000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_word_cnt", 32'(word_cnt), 32'd0);
    q.delete();
    hs_cnt = 0;
    prev_hold = 1'b0;
    cyc++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, 4'd0, 1'b1, 1'b0, 12'h000);
    idle(4, 1'b1);
    check_eq("post_rst_cnt", 32'(word_cnt), 32'd1);
    check_eq("post_rst_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_hamming_enc.md
# row_hamming_enc

Pipelined row-address encoder for the FEI4 emulator's hit-data path. It accepts an 8-bit binary pixel-row address and converts it to Gray code. It then wraps the Gray code in a 12-bit Hamming(12,8) codeword whose bit placement and parity equations match the emulator's row-address decoder. A per-word error-injection control lets the bench exercise the decoder's single-bit correction.

## Interface
- No parameters; all widths fixed.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  `in_addr` is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_addr  in  8  binary row address.
- err_en  in  1  inject a bit flip into this word; sampled with `in_addr`.
- err_pos  in  4  index of the codeword bit to flip, 0..11; values 12..15 mean no flip.
- out_valid  out  1  `out_code` is valid.
- out_ready  in  1  downstream accepts `out_code`.
- out_code  out  12  Hamming codeword.
- word_cnt  out  16  count of completed output handshakes, wraps modulo 2^16.

## Operation
- Gray conversion: g = a ^ (a >> 1), 8 bits.
- Data bit placement in `out_code` (c):
  - c[2]=g0, c[4]=g1, c[5]=g2, c[11]=g3
  - c[8]=g4, c[9]=g5, c[10]=g6, c[6]=g7
- Parity bits, chosen so every decoder check sums to 0:
  - c[0] = c2^c4^c6^c8^c10
  - c[1] = c2^c5^c6^c9^c10
  - c[3] = c4^c5^c6^c11
  - c[7] = c8^c9^c10^c11
- Injection: when `err_en`=1 and `err_pos`<12 at input handshake, c[err_pos] is inverted after the parity is computed. The flip travels with that word only.
- Stage 1 register holds: s1_valid, g, flip mask (12 bits, one-hot or zero).
- Stage 2 register holds: s2_valid and the final codeword. `out_code` and `out_valid` are driven directly from stage 2.
- Elastic pipeline, no bubbles:
  - s2 loads when s1_valid & (!s2_valid | out_ready).
  - s1 loads when in_valid & in_ready.
  - in_ready = !s1_valid | !s2_valid | out_ready.
- A valid bit clears when its stage empties without a reload.
- Word order is preserved; no word is dropped or duplicated.
- `word_cnt` increments on each out_valid & out_ready, and wraps from 0xFFFF to 0x0000.
- `out_code` holds stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n low, asynchronous):
  - s1_valid=0, s2_valid=0, out_valid=0, out_code=0x000, word_cnt=0.
  - in_ready=1 once reset is released.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+1, so it is visible in cycle N+1..N+2. This is 2 registers from input to output.
- Throughput: 1 word per cycle while out_ready=1.
- Stall, out_ready=0:
  - Both stages fill.
  - in_ready drops to 0 in the cycle after s1 fills while s2 is full.
  - At most 2 words are held.
- Simultaneous handshakes:
  - Output handshake and input accept in the same cycle with full stages: s2 takes s1, s1 takes the new word, and both valids stay 1.
- Reset mid-operation: all in-flight words are discarded and `word_cnt` clears. No output handshake is reported for discarded words.
- in_valid with in_ready=0: nothing is sampled. `err_en` and `err_pos` are sampled only at handshake.

## Test plan
- Reset, then send addr 0x00, 0x01, 0x80, 0xFF, 0x55 with out_ready=1 -> out_code 0x000, 0x007, 0x4C8, 0x04B, 0xF3C in order, each 2 cycles after accept; word_cnt=5.
- All 256 addresses back-to-back, each passed through a reference decoder model (syndrome 0, Gray-to-binary) -> decoded value equals input every word; in_ready stays 1; one output per cycle.
- addr 0x01 with err_en=1, err_pos=5 -> out_code 0x027. Same with err_pos=13 -> 0x007. Injection applies to that word only; the next word with err_en=0 is clean.
- Hold out_ready=0 and offer 3 words -> 2 are accepted, in_ready=0, out_code is stable on word 1. Release out_ready -> words come out in order and the third is accepted.
- Random in_valid and out_ready stalls over 10k words against a scoreboard -> no loss, duplication or reorder; word_cnt equals the handshake count modulo 2^16, including the wrap to 0.
- Assert rst_n low with both stages full -> out_valid=0, word_cnt=0 immediately. After release, the first new word comes out with normal latency.
